// File: rtl/cam_pkg.sv
// Shared state encoding, pin mapping and default timing for the camera power-up sequencer.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PWDN  = 3'd1,
        RST   = 3'd2,
        BOOT  = 3'd3,
        READY = 3'd4
    } state_t;

    typedef struct packed {
        logic pwdn;
        logic rst_n;
        logic busy;
        logic ready;
    } pins_t;

    localparam int unsigned T_PWDN_MS_DEF = 5;
    localparam int unsigned T_RST_US_DEF  = 10;
    localparam int unsigned T_BOOT_MS_DEF = 20;

    function automatic pins_t pins_of(input state_t s);
        pins_t p;
        case (s)
            PWDN:    p = '{pwdn: 1'b1, rst_n: 1'b0, busy: 1'b1, ready: 1'b0};
            RST:     p = '{pwdn: 1'b0, rst_n: 1'b0, busy: 1'b1, ready: 1'b0};
            BOOT:    p = '{pwdn: 1'b0, rst_n: 1'b1, busy: 1'b1, ready: 1'b0};
            READY:   p = '{pwdn: 1'b0, rst_n: 1'b1, busy: 1'b0, ready: 1'b1};
            default: p = '{pwdn: 1'b1, rst_n: 1'b0, busy: 1'b0, ready: 1'b0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: times PWDN / RESET_N from the us/ms tick strobes after a start request.
module cam_pwr_seq
    import cam_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned T_PWDN_MS = T_PWDN_MS_DEF,
    parameter int unsigned T_RST_US  = T_RST_US_DEF,
    parameter int unsigned T_BOOT_MS = T_BOOT_MS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic us_tck,
    input  logic ms_tck,
    input  logic start,
    output logic cam_pwdn,
    output logic cam_rst_n,
    output logic busy,
    output logic ready,
    output logic done
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    pins_t            pins;
    logic             own_tck;
    logic [31:0]      target;
    logic             hit;

    // Each timed state listens to exactly one tick; the other is ignored.
    always_comb begin
        own_tck = 1'b0;
        target  = '0;
        case (state)
            PWDN: begin own_tck = ms_tck; target = T_PWDN_MS; end
            RST:  begin own_tck = us_tck; target = T_RST_US;  end
            BOOT: begin own_tck = ms_tck; target = T_BOOT_MS; end
            default: ;
        endcase
    end

    assign hit = (32'(cnt) == target);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pins  <= pins_of(IDLE);
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, READY: begin
                    if (start) begin
                        state <= PWDN;
                        cnt   <= '0;
                        pins  <= pins_of(PWDN);
                    end
                end
                PWDN: begin
                    if (hit) begin
                        state <= RST;
                        cnt   <= '0;
                        pins  <= pins_of(RST);
                    end else if (own_tck && cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RST: begin
                    if (hit) begin
                        state <= BOOT;
                        cnt   <= '0;
                        pins  <= pins_of(BOOT);
                    end else if (own_tck && cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BOOT: begin
                    if (hit) begin
                        state <= READY;
                        cnt   <= '0;
                        pins  <= pins_of(READY);
                        done  <= 1'b1;
                    end else if (own_tck && cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    pins  <= pins_of(IDLE);
                end
            endcase
        end
    end

    assign cam_pwdn  = pins.pwdn;
    assign cam_rst_n = pins.rst_n;
    assign busy      = pins.busy;
    assign ready     = pins.ready;

    // A tick arriving at a saturated counter means a T_* value does not fit in CNT_W bits.
    a_cnt_sat: assert property (@(posedge clk) disable iff (rst) !(own_tck && !hit && cnt == '1));

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Scoreboard bench for cam_pwr_seq: two instances (nominal and zero-length timings) share one stimulus stream.
module tb_cam_pwr_seq;

    localparam int unsigned NCYC  = 9000;
    localparam int unsigned ARR   = NCYC + 64;
    localparam int unsigned NEVER = 32'hFFFF_0000;

    // Observed vector: {cam_pwdn, cam_rst_n, busy, ready, done}
    localparam logic [4:0] V_IDLE  = 5'b10000;
    localparam logic [4:0] V_PWDN  = 5'b10100;
    localparam logic [4:0] V_RST   = 5'b00100;
    localparam logic [4:0] V_BOOT  = 5'b01100;
    localparam logic [4:0] V_READY = 5'b01010;
    localparam logic [4:0] V_DONE  = 5'b01011;

    localparam int M_IDLE  = 0;
    localparam int M_BUSY  = 1;
    localparam int M_READY = 2;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  vec;
    } ev_t;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       us_tck = 1'b0;
    logic       ms_tck = 1'b0;
    logic       start  = 1'b0;
    logic [1:0] cam_pwdn, cam_rst_n, busy, ready, done;

    bit          us_a[ARR];
    bit          ms_a[ARR];
    ev_t         q0[$];
    ev_t         q1[$];
    int unsigned tp[2], tr[2], tb[2];
    int unsigned a[2], b[2], c[2];
    int          mode[2];
    logic [4:0]  prev_exp[2];
    logic [4:0]  prev_obs[2];
    int          cyc      = -1;
    int          n_checks = 0;
    int          n_fail   = 0;

    cam_pwr_seq #(.CNT_W(8), .T_PWDN_MS(2), .T_RST_US(3), .T_BOOT_MS(2)) dut0 (
        .clk(clk), .rst(rst), .us_tck(us_tck), .ms_tck(ms_tck), .start(start),
        .cam_pwdn(cam_pwdn[0]), .cam_rst_n(cam_rst_n[0]), .busy(busy[0]),
        .ready(ready[0]), .done(done[0])
    );

    cam_pwr_seq #(.CNT_W(8), .T_PWDN_MS(0), .T_RST_US(1), .T_BOOT_MS(0)) dut1 (
        .clk(clk), .rst(rst), .us_tck(us_tck), .ms_tck(ms_tck), .start(start),
        .cam_pwdn(cam_pwdn[1]), .cam_rst_n(cam_rst_n[1]), .busy(busy[1]),
        .ready(ready[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge index of the n-th tick strictly after edge 'from' (n=0 means 'from' itself).
    function automatic int unsigned nth(input bit use_ms, input int unsigned from, input int unsigned n);
        int unsigned seen = 0;
        if (n == 0) return from;
        for (int unsigned k = from + 1; k < ARR; k++) begin
            if (use_ms ? ms_a[k] : us_a[k]) seen++;
            if (seen == n) return k;
        end
        return NEVER;
    endfunction

    // Reference: on an accepted start, the whole timeline is derived from the tick schedule.
    task automatic model_step(input int d, input int unsigned e, input bit r, input bit s);
        logic [4:0] v;
        if (r) begin
            mode[d] = M_IDLE;
            v = V_IDLE;
        end else if (mode[d] != M_BUSY && s) begin
            mode[d] = M_BUSY;
            a[d] = nth(1'b1, e,    tp[d]) + 1;
            b[d] = nth(1'b0, a[d], tr[d]) + 1;
            c[d] = nth(1'b1, b[d], tb[d]) + 1;
            v = V_PWDN;
        end else if (mode[d] == M_BUSY) begin
            if (e == c[d]) begin
                mode[d] = M_READY;
                v = V_DONE;
            end else if (e >= b[d]) v = V_BOOT;
            else if (e >= a[d])     v = V_RST;
            else                    v = V_PWDN;
        end else if (mode[d] == M_READY) begin
            v = V_READY;
        end else begin
            v = V_IDLE;
        end
        if (v != prev_exp[d]) begin
            if (d == 0) q0.push_back('{e, v});
            else        q1.push_back('{e, v});
            prev_exp[d] = v;
        end
    endtask

    task automatic check(input int d, input logic [4:0] obs);
        ev_t ev;
        bool_empty: begin end
        if (cyc <= 3) begin
            n_checks++;
            if (obs !== V_IDLE) begin
                n_fail++;
                $display("FAIL reset_state dut%0d cyc %0d: got %b want %b", d, cyc, obs, V_IDLE);
            end
        end else if (obs !== prev_obs[d]) begin
            n_checks++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_fail++;
                $display("FAIL unexpected_change dut%0d cyc %0d: got %b want %b (no change expected)",
                         d, cyc, obs, prev_obs[d]);
            end else begin
                if (d == 0) ev = q0.pop_front();
                else        ev = q1.pop_front();
                if (int'(ev.cyc) != cyc || ev.vec !== obs) begin
                    n_fail++;
                    $display("FAIL event dut%0d: got %b at cyc %0d, want %b at cyc %0d",
                             d, obs, cyc, ev.vec, ev.cyc);
                end
            end
        end
        prev_obs[d] = obs;
    endtask

    always @(posedge clk) begin
        #1;
        check(0, {cam_pwdn[0], cam_rst_n[0], busy[0], ready[0], done[0]});
        check(1, {cam_pwdn[1], cam_rst_n[1], busy[1], ready[1], done[1]});
    end

    initial begin
        int unsigned rst_e;
        int          seqn;
        bit          r, s;
        rst_e = 0;
        seqn  = 0;
        tp[0] = 2; tr[0] = 3; tb[0] = 2;
        tp[1] = 0; tr[1] = 1; tb[1] = 0;
        for (int d = 0; d < 2; d++) begin
            mode[d]     = M_IDLE;
            prev_exp[d] = V_IDLE;
            prev_obs[d] = V_IDLE;
        end
        // Periodic ticks first (us every 4, ms every 40, coinciding every 40), then random; quiet tail.
        for (int unsigned k = 1; k < ARR; k++) begin
            if (k >= NCYC - 100) begin
                us_a[k] = 1'b0;
                ms_a[k] = 1'b0;
            end else if (k < 2000) begin
                us_a[k] = (k % 4 == 0);
                ms_a[k] = (k % 40 == 0);
            end else begin
                us_a[k] = ($urandom_range(2) == 0);
                ms_a[k] = ($urandom_range(14) == 0);
            end
        end

        for (int unsigned e = 0; e < NCYC; e++) begin
            r = (e < 3);
            s = 1'b0;
            if (e >= 1000 && e < 2000) begin
                if (e == 1010) s = 1'b1;
                if (mode[0] == M_BUSY && seqn == 1 && (e == a[0] + 1 || e == b[0] + 2)) s = 1'b1;
                if (mode[0] == M_READY && seqn == 1 && e == c[0] + 20) s = 1'b1;
                if (mode[0] == M_BUSY && seqn == 2 && e == b[0] + 3) begin
                    r = 1'b1;
                    rst_e = e;
                end
                if (mode[0] == M_IDLE && seqn == 2 && rst_e != 0 && e == rst_e + 30) s = 1'b1;
            end else if (e >= 2000 && e < NCYC - 300) begin
                s = ($urandom_range(39) == 0);
                r = ($urandom_range(1999) == 0);
            end
            if (s && !r && mode[0] != M_BUSY) seqn++;
            rst    = r;
            start  = s;
            us_tck = us_a[e];
            ms_tck = ms_a[e];
            model_step(0, e, r, s);
            model_step(1, e, r, s);
            @(negedge clk);
        end

        rst = 1'b0; start = 1'b0; us_tck = 1'b0; ms_tck = 1'b0;
        repeat (4) @(negedge clk);

        n_checks++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events dut0: got %0d outstanding, want 0", q0.size());
        end
        n_checks++;
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events dut1: got %0d outstanding, want 0", q1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
